seg7_scan_decoder: RTL

- Receive-side counterpart of the team's 8-digit multiplexed seven-segment display driver.
- Samples the scanned ANODE/CATHODE bus, waits for each digit to hold stable, and decodes the segment pattern back to a 4-bit hex value.
- Stores the decoded values in an 8-entry digit file with a combinational read port.
- Used as a bench/monitor block and as an on-chip loopback checker for the display path.

---
 rtl/seg7_pkg.sv | 57 +++++
 rtl/seg7_stable_sampler.sv | 44 ++++
 rtl/seg7_scan_decoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment table (CATHODE[6]=a .. [0]=g),
// scan FSM states and decode helpers for the scan decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Element [h] is the active-low pattern that displays hex value h.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } scan_st_t;

  // Returns {hit, value}; hit is 0 for any pattern not in the table.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] cat);
    logic [4:0] r;
    r = 5'b0;
    for (int i = 0; i < 16; i++)
      if (SEG_TABLE[i] == cat) r = {1'b1, 4'(i)};
    return r;
  endfunction

  // Returns {ok, index}; ok only when exactly one anode is driven low.
  function automatic logic [3:0] an_decode(input logic [7:0] an);
    logic [3:0] cnt;
    logic [2:0] idx;
    cnt = 4'd0;
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (!an[i]) begin
        cnt = cnt + 4'd1;
        idx = 3'(i);
      end
    return {(cnt == 4'd1), idx};
  endfunction

endpackage

// File: rtl/seg7_stable_sampler.sv
// Registers the scanned anode/cathode bus and measures how long it has been stable.
// eval pulses for one cycle in the first cycle a run reaches STABLE_CYCLES samples.
module seg7_stable_sampler #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] anode,
  input  logic [6:0] cathode,
  output logic [7:0] s_an,
  output logic [6:0] s_cat,
  output logic       chg,
  output logic       eval
);

  localparam logic [7:0] STB = 8'(STABLE_CYCLES);

  logic [7:0] run_len;
  logic       same;

  assign same = (anode == s_an) && (cathode == s_cat);

  // eval is registered together with the run_len step that reaches STB, so it is
  // high exactly while run_len first equals STB; later saturated cycles never refire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_an    <= 8'd0;
      s_cat   <= 7'd0;
      run_len <= 8'd0;
      chg     <= 1'b0;
      eval    <= 1'b0;
    end else begin
      s_an  <= anode;
      s_cat <= cathode;
      chg   <= !same;
      eval  <= same && (run_len == STB - 8'd1);
      if (!same)
        run_len <= 8'd1;
      else if (run_len != STB)
        run_len <= run_len + 8'd1;
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Decodes a scanned 8-digit seven-segment bus back into a hex digit file.
// Optional SEG7_ERR_CNT_EN adds a saturating error counter on err_count.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NDIG          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ANODE,
  input  logic [6:0] CATHODE,
  input  logic       clr,
  input  logic [2:0] rd_sel,
  output logic [3:0] rd_num,
  output logic       rd_valid,
  output logic       frame_done,
  output logic       err_anode,
  output logic       err_seg,
  output logic [7:0] err_count
);

  logic [7:0]            s_an;
  logic [6:0]            s_cat;
  logic                  chg;
  logic                  eval;
  scan_st_t              st;
  logic [NDIG-1:0][3:0]  digit;
  logic [NDIG-1:0]       valid;
  logic [NDIG-1:0]       mask;
  logic [3:0]            an_d;
  logic [4:0]            hx;
  logic [NDIG-1:0]       sel_bit;
  logic                  do_eval;

  seg7_stable_sampler #(.STABLE_CYCLES(STABLE_CYCLES)) u_smp (
    .clk     (clk),
    .reset   (reset),
    .anode   (ANODE),
    .cathode (CATHODE),
    .s_an    (s_an),
    .s_cat   (s_cat),
    .chg     (chg),
    .eval    (eval)
  );

  assign an_d    = an_decode(s_an);
  assign hx      = seg_to_hex(s_cat);
  assign sel_bit = ~s_an;            // one-hot whenever an_d reports a legal pattern
  assign do_eval = (st == ST_TRACK) && eval;

  assign rd_num   = digit[rd_sel];
  assign rd_valid = valid[rd_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= ST_IDLE;
      digit      <= '0;
      valid      <= '0;
      mask       <= '0;
      frame_done <= 1'b0;
      err_anode  <= 1'b0;
      err_seg    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_anode  <= 1'b0;
      err_seg    <= 1'b0;

      case (st)
        ST_IDLE:  if (s_an != AN_OFF) st <= ST_TRACK;
        ST_TRACK: if (eval) st <= ST_HELD;
                  else if (s_an == AN_OFF) st <= ST_IDLE;
        ST_HELD:  if (chg) st <= (s_an == AN_OFF) ? ST_IDLE : ST_TRACK;
        default:  st <= ST_IDLE;
      endcase

      if (do_eval) begin
        if (!an_d[3]) begin
          err_anode <= 1'b1;
        end else if (s_cat == SEG_BLANK) begin
          valid[an_d[2:0]] <= 1'b0;
        end else if (hx[4]) begin
          digit[an_d[2:0]] <= hx[3:0];
          valid[an_d[2:0]] <= 1'b1;
          if ((mask | sel_bit) == '1) begin
            frame_done <= 1'b1;
            mask       <= '0;
          end else begin
            mask <= mask | sel_bit;
          end
        end else begin
          err_seg <= 1'b1;
        end
      end

      // clr overrides this cycle's valid/mask update but the digit value still lands.
      if (clr) begin
        valid      <= '0;
        mask       <= '0;
        frame_done <= 1'b0;
      end
    end
  end

`ifdef SEG7_ERR_CNT_EN
  logic err_evt;
  assign err_evt = do_eval && (!an_d[3] || ((s_cat != SEG_BLANK) && !hx[4]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_count <= 8'd0;
    else if (clr)
      err_count <= 8'd0;
    else if (err_evt && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif

endmodule
